seq_divmod: RTL and testbench

//  Multi-cycle iterative divider returning quotient and remainder of a/b.

---
 rtl/divmod_pkg.sv | 25 ++
 rtl/divmod_step.sv | 41 ++++
 rtl/seq_divmod.sv | 170 +++++++++++++++++
 tb/tb_seq_divmod.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divmod_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : divmod_pkg
//  Purpose  : Shared definitions for the sequential divider: FSM state
//             encoding and the step-counter width helper.
//  Contents : state_t   - IDLE / CALC / FIX / DONE
//             cnt_width - counter width able to hold DATAWIDTH,
//                         i.e. CNT_W = $clog2(DATAWIDTH+1)
//  Revision : 1.0 - initial release
// ============================================================================
package divmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divmod_step.sv
`default_nettype none
// ============================================================================
//  Module   : divmod_step
//  Purpose  : One combinational restoring-division step. The partial
//             remainder and quotient shift left together as a single
//             register pair. The divisor is subtracted from the shifted
//             remainder; when the result is non-negative it is kept and a 1
//             enters the quotient.
//  Ports    : rem_in   [WIDTH:0]   partial remainder before the step
//             quo_in   [WIDTH-1:0] partial quotient / remaining dividend bits
//             divisor  [WIDTH-1:0] divisor magnitude
//             rem_out  [WIDTH:0]   partial remainder after the step
//             quo_out  [WIDTH-1:0] partial quotient after the step
//  Revision : 1.0 - initial release
// ============================================================================
module divmod_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // One extra bit of headroom so the shift never loses the remainder MSB.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             take;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign trial   = shifted - {2'b00, divisor};
    assign take    = (shifted >= {2'b00, divisor});

    // The remainder always stays below the divisor, so the top bit of the
    // widened value is zero and truncation is lossless.
    assign rem_out = (WIDTH+1)'(take ? trial : shifted);
    assign quo_out = {quo_in[WIDTH-2:0], take};

endmodule
`default_nettype wire

// File: rtl/seq_divmod.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divmod
//  Purpose  : Multi-cycle iterative divider producing quotient (truncated
//             toward zero) and remainder (sign of dividend) of a/b, with
//             signed/unsigned mode, divide-by-zero flag and valid/ready
//             handshakes on both sides. One operation is in flight at a time.
//  Ports    : Clk       clock, rising edge
//             Rst       synchronous active-low reset
//             in_valid  / in_ready   operand handshake
//             a, b      dividend, divisor
//             sgn       1 = two's-complement signed, 0 = unsigned
//             out_valid / out_ready  result handshake
//             q, r      quotient, remainder (registered)
//             dz        divide-by-zero flag for this result
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divmod
    import divmod_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] q,
    output logic [DATAWIDTH-1:0] r,
    output logic                 dz
);

    localparam int                CNT_W     = cnt_width(DATAWIDTH);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATAWIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t                 state;
    state_t                 state_next;

    logic [CNT_W-1:0]       cnt;
    logic [DATAWIDTH:0]     rem;
    logic [DATAWIDTH-1:0]   quo;
    logic [DATAWIDTH-1:0]   divisor;
    logic                   sign_q;
    logic                   sign_r;

    logic [DATAWIDTH:0]     rem_step;
    logic [DATAWIDTH-1:0]   quo_step;

    logic                   accept;
    logic                   b_zero;
    logic                   a_neg;
    logic                   b_neg;
    logic [DATAWIDTH-1:0]   a_mag;
    logic [DATAWIDTH-1:0]   b_mag;

    // Status outputs decode the state register only: no input-to-output path.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign accept = in_valid && (state == IDLE);
    assign b_zero = (b == '0);

    // The magnitude of the most negative value is 2^(DATAWIDTH-1), which is
    // still representable as an unsigned DATAWIDTH-bit number, so MIN/-1
    // needs no special handling and wraps back to MIN after correction.
    assign a_neg = sgn & a[DATAWIDTH-1];
    assign b_neg = sgn & b[DATAWIDTH-1];
    assign a_mag = a_neg ? ({DATAWIDTH{1'b0}} - a) : a;
    assign b_mag = b_neg ? ({DATAWIDTH{1'b0}} - b) : b;

    divmod_step #(
        .WIDTH   (DATAWIDTH)
    ) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            q       <= '0;
            r       <= '0;
            dz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (b_zero) begin
                            // Divide by zero bypasses the iteration entirely.
                            q  <= '1;
                            r  <= a;
                            dz <= 1'b1;
                        end else begin
                            cnt     <= '0;
                            rem     <= '0;
                            quo     <= a_mag;
                            divisor <= b_mag;
                            sign_q  <= a_neg ^ b_neg;
                            sign_r  <= a_neg;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CNT_ONE;
                end
                FIX: begin
                    q  <= sign_q ? ({DATAWIDTH{1'b0}} - quo) : quo;
                    r  <= sign_r ? ({DATAWIDTH{1'b0}} - rem[DATAWIDTH-1:0])
                                 : rem[DATAWIDTH-1:0];
                    dz <= 1'b0;
                end
                default: begin
                    // DONE: results held stable until accepted.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divmod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divmod
//  Purpose  : Self-checking bench for seq_divmod (DATAWIDTH = 16) using
//             directed vectors with hand-computed results plus a random
//             sweep against a reference model of / and %.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divmod;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;

    int checks;
    int failures;

    seq_divmod #(
        .DATAWIDTH (16)
    ) dut (
        .Clk       (clk),
        .Rst       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and collect its result. lat counts rising edges
    // from the accepting edge until out_valid is seen.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_b,
                          input logic ts, output logic [15:0] oq,
                          output logic [15:0] orr, output logic odz,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        a        = ta;
        b        = tb_b;
        sgn      = ts;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands after accept; they must not affect the result.
        a        = 16'($urandom);
        b        = 16'($urandom);
        sgn      = ~ts;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL op_timeout a=%h b=%h sgn=%0d got out_valid=%0d want 1",
                     ta, tb_b, ts, out_valid);
        end
        oq  = q;
        orr = r;
        odz = dz;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 16'h0; b = 16'h0; sgn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 16'h0 ||
            r !== 16'h0 || dz !== 1'b0) begin
            failures++;
            $display("FAIL reset got in_ready=%b out_valid=%b q=%h r=%h dz=%b want 1 0 0000 0000 0",
                     in_ready, out_valid, q, r, dz);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [15:0] rq, rr;
        logic        rdz;
        int          lat;
        run_op(16'd100, 16'd7, 1'b0, rq, rr, rdz, lat);
        checks++;
        if (rq !== 16'd14 || rr !== 16'd2 || rdz !== 1'b0) begin
            failures++;
            $display("FAIL unsigned_100_7 got q=%0d r=%0d dz=%b want q=14 r=2 dz=0", rq, rr, rdz);
        end
        checks++;
        if (lat != 18) begin
            failures++;
            $display("FAIL latency_nonzero got %0d want 18", lat);
        end
    endtask

    task automatic test_signed();
        logic [15:0] rq, rr;
        logic        rdz;
        int          lat;
        run_op(16'hFFF9, 16'd2, 1'b1, rq, rr, rdz, lat);
        checks++;
        if (rq !== 16'hFFFD || rr !== 16'hFFFF || rdz !== 1'b0) begin
            failures++;
            $display("FAIL signed_m7_2 got q=%h r=%h dz=%b want q=fffd r=ffff dz=0", rq, rr, rdz);
        end
        run_op(16'd7, 16'hFFFE, 1'b1, rq, rr, rdz, lat);
        checks++;
        if (rq !== 16'hFFFD || rr !== 16'h0001 || rdz !== 1'b0) begin
            failures++;
            $display("FAIL signed_7_m2 got q=%h r=%h dz=%b want q=fffd r=0001 dz=0", rq, rr, rdz);
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] rq, rr;
        logic        rdz;
        int          lat;
        for (int m = 0; m < 2; m++) begin
            run_op(16'h1234, 16'h0000, m[0], rq, rr, rdz, lat);
            checks++;
            if (rq !== 16'hFFFF || rr !== 16'h1234 || rdz !== 1'b1) begin
                failures++;
                $display("FAIL div_zero sgn=%0d got q=%h r=%h dz=%b want q=ffff r=1234 dz=1",
                         m, rq, rr, rdz);
            end
            checks++;
            if (lat != 1) begin
                failures++;
                $display("FAIL latency_div_zero sgn=%0d got %0d want 1", m, lat);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] rq, rr;
        logic        rdz;
        int          lat;
        run_op(16'h8000, 16'hFFFF, 1'b1, rq, rr, rdz, lat);
        checks++;
        if (rq !== 16'h8000 || rr !== 16'h0000 || rdz !== 1'b0) begin
            failures++;
            $display("FAIL signed_overflow got q=%h r=%h dz=%b want q=8000 r=0000 dz=0", rq, rr, rdz);
        end
        run_op(16'h8000, 16'hFFFF, 1'b0, rq, rr, rdz, lat);
        checks++;
        if (rq !== 16'h0000 || rr !== 16'h8000 || rdz !== 1'b0) begin
            failures++;
            $display("FAIL unsigned_8000_ffff got q=%h r=%h dz=%b want q=0000 r=8000 dz=0", rq, rr, rdz);
        end
    endtask

    task automatic test_backpressure();
        int n;
        a = 16'd100; b = 16'd7; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL backpressure_timeout got out_valid=%b want 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = 16'h0005; b = 16'h0001; sgn = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (q !== 16'd14 || r !== 16'd2 || dz !== 1'b0 ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got q=%0d r=%0d dz=%b ov=%b ir=%b want 14 2 0 1 0",
                         i, q, r, dz, out_valid, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        // The in_valid pulses during DONE must not have queued an operation.
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_queued_op got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] rq, rr;
        logic        rdz;
        int          lat;
        a = 16'd1000; b = 16'd3; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 16'h0 ||
            r !== 16'h0 || dz !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got ir=%b ov=%b q=%h r=%h dz=%b want 1 0 0000 0000 0",
                     in_ready, out_valid, q, r, dz);
        end
        rst_n = 1'b1;
        run_op(16'd9, 16'd3, 1'b0, rq, rr, rdz, lat);
        checks++;
        if (rq !== 16'd3 || rr !== 16'd0 || rdz !== 1'b0 || lat != 18) begin
            failures++;
            $display("FAIL after_reset_9_3 got q=%0d r=%0d dz=%b lat=%0d want 3 0 0 18",
                     rq, rr, rdz, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] ta, tbv, eq, er, rq, rr;
        logic        ts, edz, rdz;
        int          lat, sa, sb;
        for (int i = 0; i < 1500; i++) begin
            ta  = 16'($urandom);
            tbv = 16'($urandom);
            ts  = 1'($urandom);
            case ($urandom_range(0, 15))
                0:       tbv = 16'h0000;
                1:       tbv = 16'hFFFF;
                2:       ta  = 16'h8000;
                3:       tbv = 16'($urandom_range(1, 5));
                default: ;
            endcase
            if (tbv == 16'h0000) begin
                eq = 16'hFFFF; er = ta; edz = 1'b1;
            end else if (ts) begin
                sa  = $signed(ta);
                sb  = $signed(tbv);
                eq  = 16'(sa / sb);
                er  = 16'(sa % sb);
                edz = 1'b0;
            end else begin
                eq  = ta / tbv;
                er  = ta % tbv;
                edz = 1'b0;
            end
            run_op(ta, tbv, ts, rq, rr, rdz, lat);
            checks++;
            if (rq !== eq || rr !== er || rdz !== edz) begin
                failures++;
                $display("FAIL random a=%h b=%h sgn=%b got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         ta, tbv, ts, rq, rr, rdz, eq, er, edz);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
